// File: rtl/spi_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_bus_arbiter
// Brief    : Round-robin arbiter/sequencer sharing one SPI master between
//            NUM_REQ requesters; optional WAIT timeout via ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module spi_bus_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_W        = 8,
  parameter int GAP_TICKS     = 2,
  parameter int TIMEOUT_TICKS = 16
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      CTRL_TICK,
  input  logic [NUM_REQ-1:0]        REQ,
  input  logic [NUM_REQ*DATA_W-1:0] REQ_DATA,
  output logic [NUM_REQ-1:0]        GNT,
  output logic [NUM_REQ-1:0]        DONE,
  output logic                      ERR,
  output logic [DATA_W-1:0]         RX_DATA,
  output logic                      BUSY,
  output logic                      SPI_START,
  output logic [DATA_W-1:0]         SPI_TX,
  input  logic                      SPI_BUSY,
  input  logic                      SPI_DONE,
  input  logic [DATA_W-1:0]         SPI_RX
);

  localparam int c_IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int c_CNT_MAX = (GAP_TICKS > TIMEOUT_TICKS) ? GAP_TICKS : TIMEOUT_TICKS;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
  localparam logic [c_CNT_W-1:0] c_GAP_LAST = c_CNT_W'(GAP_TICKS - 1);
  localparam logic [c_IDX_W-1:0] c_LAST_RST = c_IDX_W'(NUM_REQ - 1);
`ifdef ARB_TIMEOUT_EN
  localparam logic [c_CNT_W-1:0] c_TO_LAST  = c_CNT_W'(TIMEOUT_TICKS - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_START   = 2'd1,
    S_WAIT    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [NUM_REQ-1:0]   r_gnt,     w_gnt_nxt;
  logic [NUM_REQ-1:0]   r_done,    w_done_nxt;
  logic [DATA_W-1:0]    r_rx_data, w_rx_nxt;
  logic [DATA_W-1:0]    r_spi_tx,  w_tx_nxt;
  logic                 r_spi_start, w_start_nxt;
  logic                 r_busy;
  logic [c_IDX_W-1:0]   r_last,    w_last_nxt;
  logic [c_CNT_W-1:0]   r_cnt,     w_cnt_nxt;
`ifdef ARB_TIMEOUT_EN
  logic                 r_err,     w_err_nxt;
`endif

  logic [DATA_W-1:0]    w_req_word [NUM_REQ];
  logic [c_IDX_W-1:0]   w_idx;
  logic [c_IDX_W-1:0]   w_win;
  logic                 w_found;

  genvar g;
  generate
    for (g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign w_req_word[g] = REQ_DATA[g*DATA_W +: DATA_W];
    end
  endgenerate

  // Walk downward so the last hit is the nearest set bit after r_last.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_last;
    w_idx   = r_last;
    for (int i = NUM_REQ; i >= 1; i--) begin
      w_idx = c_IDX_W'((int'(r_last) + i) % NUM_REQ);
      if (REQ[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_done_nxt  = '0;
    w_rx_nxt    = r_rx_data;
    w_tx_nxt    = r_spi_tx;
    w_start_nxt = 1'b0;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
`ifdef ARB_TIMEOUT_EN
    w_err_nxt   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (CTRL_TICK && w_found && !SPI_BUSY) begin
          w_state_nxt        = S_START;
          w_gnt_nxt          = '0;
          w_gnt_nxt[w_win]   = 1'b1;
          w_tx_nxt           = w_req_word[w_win];
          w_last_nxt         = w_win;
          w_start_nxt        = 1'b1;
          w_cnt_nxt          = '0;
        end
      end
      S_START: begin
        w_state_nxt = S_WAIT;
        w_cnt_nxt   = '0;
      end
      S_WAIT: begin
        if (SPI_DONE) begin
          w_state_nxt = S_RELEASE;
          w_rx_nxt    = SPI_RX;
          w_done_nxt  = r_gnt;
          w_gnt_nxt   = '0;
          w_cnt_nxt   = '0;
        end
`ifdef ARB_TIMEOUT_EN
        else if (CTRL_TICK) begin
          if (r_cnt == c_TO_LAST) begin
            w_state_nxt = S_RELEASE;
            w_done_nxt  = r_gnt;
            w_err_nxt   = 1'b1;
            w_gnt_nxt   = '0;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
`endif
      end
      S_RELEASE: begin
        // The closing gap tick only returns to IDLE; arbitration waits for the next one.
        if (CTRL_TICK) begin
          if (r_cnt == c_GAP_LAST) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_gnt       <= '0;
      r_done      <= '0;
      r_rx_data   <= '0;
      r_spi_tx    <= '0;
      r_spi_start <= 1'b0;
      r_busy      <= 1'b0;
      r_last      <= c_LAST_RST;
      r_cnt       <= '0;
`ifdef ARB_TIMEOUT_EN
      r_err       <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_done      <= w_done_nxt;
      r_rx_data   <= w_rx_nxt;
      r_spi_tx    <= w_tx_nxt;
      r_spi_start <= w_start_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_last      <= w_last_nxt;
      r_cnt       <= w_cnt_nxt;
`ifdef ARB_TIMEOUT_EN
      r_err       <= w_err_nxt;
`endif
    end
  end

  assign GNT       = r_gnt;
  assign DONE      = r_done;
  assign RX_DATA   = r_rx_data;
  assign SPI_TX    = r_spi_tx;
  assign SPI_START = r_spi_start;
  assign BUSY      = r_busy;
`ifdef ARB_TIMEOUT_EN
  assign ERR       = r_err;
`else
  assign ERR       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_bus_arbiter
// Brief    : Vector table plus scoreboard bench for spi_bus_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_bus_arbiter;

  localparam int NUM_REQ       = 4;
  localparam int DATA_W        = 8;
  localparam int GAP_TICKS     = 2;
  localparam int TIMEOUT_TICKS = 16;

  logic        CLK, RST, CTRL_TICK;
  logic [3:0]  REQ;
  logic [31:0] REQ_DATA;
  logic [3:0]  GNT, DONE;
  logic        ERR;
  logic [7:0]  RX_DATA;
  logic        BUSY, SPI_START;
  logic [7:0]  SPI_TX;
  logic        SPI_BUSY, SPI_DONE;
  logic [7:0]  SPI_RX;

  spi_bus_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .DATA_W       (DATA_W),
    .GAP_TICKS    (GAP_TICKS),
    .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .CTRL_TICK(CTRL_TICK),
    .REQ      (REQ),
    .REQ_DATA (REQ_DATA),
    .GNT      (GNT),
    .DONE     (DONE),
    .ERR      (ERR),
    .RX_DATA  (RX_DATA),
    .BUSY     (BUSY),
    .SPI_START(SPI_START),
    .SPI_TX   (SPI_TX),
    .SPI_BUSY (SPI_BUSY),
    .SPI_DONE (SPI_DONE),
    .SPI_RX   (SPI_RX)
  );

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [7:0]  rx;
    logic [3:0]  gnt;
    logic [7:0]  tx;
    bit          early;
    bit          drop;
  } vec_t;

  typedef struct {
    logic [3:0] gnt;
    logic [7:0] tx;
    logic [7:0] rx;
    logic       err;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  vec_t       vecs[10];
  int         n_checks = 0;
  int         n_errors = 0;
  logic       prev_start = 1'b0;
  logic [7:0] last_rx = 8'h00;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic tick();
    CTRL_TICK = 1'b1;
    cyc();
    CTRL_TICK = 1'b0;
  endtask

  // Scoreboard consumer: grant/TX at start, DONE/RX/ERR at completion.
  always @(negedge CLK) begin
    if (!RST) begin
      if (SPI_START) begin
        chk("start_width", 32'(prev_start), 32'd0);
        chk("sb_nonempty_at_start", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          chk("gnt", 32'(GNT), 32'(sb[0].gnt));
          chk("spi_tx", 32'(SPI_TX), 32'(sb[0].tx));
        end
      end
      if (DONE != 4'b0000) begin
        chk("sb_nonempty_at_done", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("done", 32'(DONE), 32'(mon_e.gnt));
          chk("rx_data", 32'(RX_DATA), 32'(mon_e.rx));
          chk("err", 32'(ERR), 32'(mon_e.err));
          chk("done_gnt_clear", 32'(GNT), 32'd0);
        end
      end
    end
    prev_start = SPI_START;
  end

  task automatic start_txn(input logic [3:0] req, input logic [31:0] data,
                           input logic [3:0] gnt, input logic [7:0] tx,
                           input logic [7:0] rx, input logic err,
                           input bit early, input bit drop);
    exp_t e;
    e.gnt = gnt; e.tx = tx; e.rx = rx; e.err = err;
    sb.push_back(e);
    REQ      = req;
    REQ_DATA = data;
    tick();
    chk("start_hi", 32'(SPI_START), 32'd1);
    chk("busy_start", 32'(BUSY), 32'd1);
    REQ_DATA = ~data;
    if (drop) REQ = 4'b0000;
    SPI_DONE = early;
    SPI_RX   = 8'hEE;
    cyc();
    SPI_DONE = 1'b0;
    chk("start_lo", 32'(SPI_START), 32'd0);
    chk("busy_wait", 32'(BUSY), 32'd1);
    chk("tx_hold", 32'(SPI_TX), 32'(tx));
  endtask

  task automatic gap_phase();
    cyc();
    chk("sb_drained", sb.size(), 32'd0);
    chk("done_one_cycle", 32'(DONE), 32'd0);
    for (int k = 0; k < GAP_TICKS; k++) begin
      chk("gap_busy", 32'(BUSY), 32'd1);
      tick();
    end
    chk("gap_idle", 32'(BUSY), 32'd0);
    chk("gap_no_grant", 32'(GNT), 32'd0);
  endtask

  // Completion coincides with a control tick; completion must win.
  task automatic finish_txn(input logic [7:0] rx);
    repeat (2) cyc();
    chk("no_early_done", 32'(DONE), 32'd0);
    SPI_RX    = rx;
    SPI_DONE  = 1'b1;
    CTRL_TICK = 1'b1;
    cyc();
    SPI_DONE  = 1'b0;
    CTRL_TICK = 1'b0;
    SPI_RX    = ~rx;
    chk("gnt_clear", 32'(GNT), 32'd0);
    chk("rx_now", 32'(RX_DATA), 32'(rx));
    last_rx = rx;
    gap_phase();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{4'b1111, 32'h44332211, 8'h5A, 4'b0001, 8'h11, 1'b0, 1'b0};
    vecs[1] = '{4'b0010, 32'h0000A500, 8'h3C, 4'b0010, 8'hA5, 1'b0, 1'b0};
    vecs[2] = '{4'b1111, 32'hD4C3B2A1, 8'h01, 4'b0100, 8'hC3, 1'b0, 1'b0};
    vecs[3] = '{4'b1111, 32'hD4C3B2A1, 8'h02, 4'b1000, 8'hD4, 1'b1, 1'b0};
    vecs[4] = '{4'b1111, 32'hD4C3B2A1, 8'h03, 4'b0001, 8'hA1, 1'b0, 1'b0};
    vecs[5] = '{4'b1010, 32'h88776655, 8'h04, 4'b0010, 8'h66, 1'b0, 1'b0};
    vecs[6] = '{4'b1010, 32'h88776655, 8'h05, 4'b1000, 8'h88, 1'b0, 1'b0};
    vecs[7] = '{4'b1010, 32'h88776655, 8'h06, 4'b0010, 8'h66, 1'b0, 1'b0};
    vecs[8] = '{4'b0001, 32'h88776655, 8'h07, 4'b0001, 8'h55, 1'b0, 1'b0};
    vecs[9] = '{4'b1001, 32'h88776655, 8'h08, 4'b1000, 8'h88, 1'b0, 1'b1};

    RST = 1'b1; CTRL_TICK = 1'b0; REQ = '0; REQ_DATA = '0;
    SPI_BUSY = 1'b0; SPI_DONE = 1'b0; SPI_RX = '0;
    repeat (2) cyc();
    chk("rst_gnt", 32'(GNT), 32'd0);
    chk("rst_done_err", 32'({DONE, ERR}), 32'd0);
    chk("rst_rx_tx", 32'({RX_DATA, SPI_TX}), 32'd0);
    chk("rst_start_busy", 32'({SPI_START, BUSY}), 32'd0);
    RST = 1'b0;
    cyc();
    tick();
    chk("idle_no_req", 32'(BUSY), 32'd0);

    // Abort mid-transfer with an asynchronous reset between clock edges.
    start_txn(4'b0100, 32'h00C00000, 4'b0100, 8'hC0, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc();
    #2;
    RST = 1'b1;
    #1;
    chk("arst_gnt", 32'(GNT), 32'd0);
    chk("arst_tx", 32'(SPI_TX), 32'd0);
    chk("arst_busy", 32'(BUSY), 32'd0);
    sb.delete();
    cyc();
    RST = 1'b0;
    REQ = 4'b0000;
    cyc();

    for (int v = 0; v < 10; v++) begin
      start_txn(vecs[v].req, vecs[v].data, vecs[v].gnt, vecs[v].tx,
                vecs[v].rx, 1'b0, vecs[v].early, vecs[v].drop);
      finish_txn(vecs[v].rx);
    end

    // Third tick after DONE is blocked by a busy master, next free tick grants.
    start_txn(4'b1111, 32'hD4C3B2A1, 4'b0001, 8'hA1, 8'h21, 1'b0, 1'b0, 1'b0);
    finish_txn(8'h21);
    REQ_DATA = 32'hD4C3B2A1;
    SPI_BUSY = 1'b1;
    tick();
    chk("spi_busy_no_gnt", 32'(GNT), 32'd0);
    chk("spi_busy_idle", 32'(BUSY), 32'd0);
    SPI_BUSY = 1'b0;
    start_txn(4'b1111, 32'hD4C3B2A1, 4'b0010, 8'hB2, 8'h22, 1'b0, 1'b0, 1'b0);
    finish_txn(8'h22);

`ifdef ARB_TIMEOUT_EN
    start_txn(4'b0100, 32'hD4C3B2A1, 4'b0100, 8'hC3, last_rx, 1'b1, 1'b0, 1'b0);
    repeat (TIMEOUT_TICKS - 1) tick();
    chk("to_not_yet", 32'(DONE), 32'd0);
    chk("to_busy", 32'(BUSY), 32'd1);
    tick();
    chk("to_done", 32'(DONE), 32'h4);
    chk("to_err", 32'(ERR), 32'd1);
    gap_phase();

    start_txn(4'b1000, 32'hD4C3B2A1, 4'b1000, 8'hD4, 8'h77, 1'b0, 1'b0, 1'b0);
    repeat (TIMEOUT_TICKS - 1) tick();
    SPI_DONE = 1'b1;
    SPI_RX   = 8'h77;
    tick();
    SPI_DONE = 1'b0;
    chk("sim_err", 32'(ERR), 32'd0);
    chk("sim_rx", 32'(RX_DATA), 32'h77);
    gap_phase();
`else
    start_txn(4'b0100, 32'hD4C3B2A1, 4'b0100, 8'hC3, 8'h99, 1'b0, 1'b0, 1'b0);
    repeat (100) tick();
    chk("wait_persist_busy", 32'(BUSY), 32'd1);
    chk("wait_persist_gnt", 32'(GNT), 32'h4);
    chk("wait_persist_err", 32'({DONE, ERR}), 32'd0);
    finish_txn(8'h99);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
